// File: rtl/router_pkg.sv
// Shared definitions for the router node's bit-serial message buffers.
// Holds the buffer state encoding, node-level constants and the counter width.
package router_pkg;

  localparam int CELL_ADDR_W = 4;
  localparam int NUM_BUFFERS = 7;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    FULL,
    SEND
  } state_t;

  // Terminal count for a phase lasting n cycles.
  function automatic logic [CNT_W-1:0] last_idx(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Left-shifting register: serial load at the LSB, or shift out with the MSB exposed.
// Loading takes priority over shifting out.
module serial_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  input  logic shift_en,
  input  logic sin,
  output logic msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= WIDTH'({q, sin});
    end else if (shift_en) begin
      q <= WIDTH'({q, 1'b0});
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/router_msg_buffer.sv
// Bit-serial message buffer: captures start/address/payload from rx_bit, requests
// delivery, then streams the payload MSB-first to the distributor while granted.
module router_msg_buffer
  import router_pkg::*;
#(
  parameter int ADDR_W    = CELL_ADDR_W,
  parameter int PAYLOAD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  output logic              rx_ready,
  output logic              req,
  input  logic              grant,
  output logic              bit_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              done,
  output logic              overrun
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic             addr_en;
  logic             pay_load;
  logic             pay_shift;
  logic             pay_msb;
  logic             ovr_set;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_en   = 1'b0;
    pay_load  = 1'b0;
    pay_shift = 1'b0;
    ovr_set   = 1'b0;
    req       = 1'b0;
    bit_out   = 1'b0;
    done      = 1'b0;
    rx_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_bit) begin
          state_d = HDR;
          cnt_d   = '0;
        end
      end
      HDR: begin
        addr_en = 1'b1;
        if (cnt_q == last_idx(ADDR_W)) begin
          state_d = PAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PAY: begin
        pay_load = 1'b1;
        if (cnt_q == last_idx(PAYLOAD_W)) begin
          state_d = FULL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FULL: begin
        req     = 1'b1;
        ovr_set = rx_bit;
        if (grant) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        ovr_set = rx_bit;
        // A dropped grant freezes the shift and the count until it returns.
        if (grant) begin
          bit_out   = pay_msb;
          pay_shift = 1'b1;
          if (cnt_q == last_idx(PAYLOAD_W)) begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (addr_en) begin
        addr_q <= ADDR_W'({addr_q, rx_bit});
      end
      overrun <= overrun | ovr_set;
    end
  end

  serial_shift_reg #(
    .WIDTH(PAYLOAD_W)
  ) u_payload (
    .clk     (clk),
    .rst     (rst),
    .load_en (pay_load),
    .shift_en(pay_shift),
    .sin     (rx_bit),
    .msb     (pay_msb)
  );

  assign addr_out = addr_q;

endmodule

// File: tb/tb_router_msg_buffer.sv
// Directed bench for router_msg_buffer (ADDR_W=4, PAYLOAD_W=8) with a queue-based
// message model checked every cycle plus literal expectations per scenario.
module tb_router_msg_buffer;

  localparam int AW = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_bit = 1'b0;
  logic          grant = 1'b0;
  logic          rx_ready, req, bit_out, done, overrun;
  logic [AW-1:0] addr_out;

  int n_cmp = 0;
  int n_bad = 0;

  router_msg_buffer #(.ADDR_W(AW), .PAYLOAD_W(PW)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_bit  (rx_bit),
    .rx_ready(rx_ready),
    .req     (req),
    .grant   (grant),
    .bit_out (bit_out),
    .addr_out(addr_out),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Message-level model: bits after a start bit are collected; the first AW form the
  // address, the rest queue up as payload that drains one bit per granted cycle.
  int          m_rcv  = -1;
  logic [AW-1:0] m_addr = '0;
  bit          m_held = 1'b0;
  bit          m_send = 1'b0;
  bit          m_ovr  = 1'b0;
  bit          m_sq[$];

  initial begin : model_compare
    logic e_ready, e_bit, e_done;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ready = (m_rcv < 0) && !m_held && !m_send;
      e_bit   = m_send && grant && m_sq[0];
      e_done  = m_send && grant && (m_sq.size() == 1);
      chk("m_rx_ready", {31'd0, rx_ready}, {31'd0, e_ready});
      chk("m_req",      {31'd0, req},      {31'd0, m_held});
      chk("m_bit_out",  {31'd0, bit_out},  {31'd0, e_bit});
      chk("m_done",     {31'd0, done},     {31'd0, e_done});
      chk("m_addr_out", {28'd0, addr_out}, {28'd0, m_addr});
      chk("m_overrun",  {31'd0, overrun},  {31'd0, m_ovr});
      if (rst) begin
        m_rcv = -1; m_held = 0; m_send = 0; m_ovr = 0; m_addr = '0;
        m_sq.delete();
      end else if (m_send) begin
        if (rx_bit) m_ovr = 1;
        if (grant) begin
          void'(m_sq.pop_front());
          if (m_sq.size() == 0) m_send = 0;
        end
      end else if (m_held) begin
        if (rx_bit) m_ovr = 1;
        if (grant) begin
          m_held = 0;
          m_send = 1;
        end
      end else if (m_rcv >= 0) begin
        m_rcv++;
        if (m_rcv <= AW) m_addr = {m_addr[AW-2:0], rx_bit};
        else m_sq.push_back(rx_bit);
        if (m_rcv == AW + PW) begin
          m_rcv  = -1;
          m_held = 1;
        end
      end else if (rx_bit) begin
        m_rcv = 0;
      end
    end
  end

  // One clock: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic g, input logic rs);
    @(posedge clk);
    #1;
    rx_bit = r;
    grant  = g;
    rst    = rs;
    @(negedge clk);
  endtask

  task automatic send_msg(input logic [AW-1:0] a, input logic [PW-1:0] p, output logic rdy_start);
    cyc(1'b1, 1'b0, 1'b0);
    rdy_start = rx_ready;
    for (int i = AW - 1; i >= 0; i--) cyc(a[i], 1'b0, 1'b0);
    for (int i = PW - 1; i >= 0; i--) cyc(p[i], 1'b0, 1'b0);
  endtask

  task automatic deliver(output logic [PW-1:0] b, output logic last_done, output int n_done);
    cyc(1'b0, 1'b1, 1'b0);
    b = '0;
    n_done = 0;
    for (int i = 0; i < PW; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      b = {b[PW-2:0], bit_out};
      if (done) n_done++;
    end
    last_done = done;
  endtask

  initial begin : stimulus
    logic [PW-1:0] b;
    logic          ld, rdy, pause_or;
    int            nd;

    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_req",      {31'd0, req},      32'd0);
    chk("rst_addr",     {28'd0, addr_out}, 32'd0);
    chk("rst_bit_done", {30'd0, bit_out, done}, 32'd0);
    chk("rst_overrun",  {31'd0, overrun},  32'd0);

    // Basic delivery
    send_msg(4'b1010, 8'hA5, rdy);
    cyc(1'b0, 1'b0, 1'b0);
    chk("basic_req",  {31'd0, req},      32'd1);
    chk("basic_addr", {28'd0, addr_out}, 32'd10);
    deliver(b, ld, nd);
    chk("basic_bits", {24'd0, b}, 32'hA5);
    chk("basic_done", {31'd0, ld}, 32'd1);
    chk("basic_ndone", nd, 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("basic_ready_after", {31'd0, rx_ready}, 32'd1);

    // Delayed grant
    send_msg(4'b0110, 8'hA5, rdy);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("delay_req",  {31'd0, req},      32'd1);
    chk("delay_addr", {28'd0, addr_out}, 32'd6);
    deliver(b, ld, nd);
    chk("delay_bits", {24'd0, b}, 32'hA5);

    // Grant pause after the third payload bit
    send_msg(4'b0011, 8'hF0, rdy);
    cyc(1'b0, 1'b1, 1'b0);
    b = '0;
    pause_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      b = {b[PW-2:0], bit_out};
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      pause_or = pause_or | bit_out | done;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      b = {b[PW-2:0], bit_out};
    end
    chk("pause_quiet", {31'd0, pause_or}, 32'd0);
    chk("pause_bits",  {24'd0, b}, 32'hF0);

    // Overrun while FULL
    send_msg(4'b0101, 8'hC3, rdy);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    deliver(b, ld, nd);
    chk("ovr_bits",   {24'd0, b}, 32'hC3);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of the payload
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(i == 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("mrst_req",      {31'd0, req},      32'd0);
    chk("mrst_overrun",  {31'd0, overrun},  32'd0);
    chk("mrst_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_msg(4'b0011, 8'h5A, rdy);
    cyc(1'b0, 1'b0, 1'b0);
    chk("mrst_addr", {28'd0, addr_out}, 32'd3);
    deliver(b, ld, nd);
    chk("mrst_bits", {24'd0, b}, 32'h5A);

    // Back-to-back messages with no dead cycle
    send_msg(4'b0110, 8'h81, rdy);
    deliver(b, ld, nd);
    chk("b2b_bits1", {24'd0, b}, 32'h81);
    send_msg(4'b1001, 8'h7E, rdy);
    chk("b2b_ready_at_start", {31'd0, rdy}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("b2b_addr2", {28'd0, addr_out}, 32'd9);
    deliver(b, ld, nd);
    chk("b2b_bits2", {24'd0, b}, 32'h7E);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
